// File: rtl/test.sv
// 8-bit single-cycle processor: fixed 32-entry instruction ROM, 4x8 register file,
// 32x8 data memory. RawOutput shows the most recent register write-back value.
module test (
  input  logic       clk,
  input  logic       Reset,
  output logic [7:0] RawOutput
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_JMP = 2'b11
  } op_e;

  logic [7:0] pc;
  logic [7:0] regs [4];
  logic [7:0] mem  [32];

  logic [7:0] instr;
  op_e        op;
  logic [1:0] rs, rt, rd;
  logic [7:0] sum;
  logic [4:0] addr;
  logic [7:0] load;
  logic [7:0] pc_next;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    instr = 8'h00;
    case (pc[4:0])
      5'd0: instr = 8'h45;
      5'd1: instr = 8'h16;
      5'd2: instr = 8'h27;
      5'd3: instr = 8'h8C;
      5'd4: instr = 8'h40;
      5'd5: instr = 8'h30;
      5'd6: instr = 8'hFE;
      default: instr = 8'h00;
    endcase
  end

  assign op = op_e'(instr[7:6]);
  assign rs = instr[5:4];
  assign rt = instr[3:2];
  assign rd = instr[1:0];

  assign sum  = regs[rs] + regs[rt];
  // Data address is computed in 8 bits and only the low 5 bits select the word.
  assign addr = 5'(regs[rs] + {{6{instr[1]}}, instr[1:0]});
  assign load = mem[addr];

  always_comb begin
    pc_next = pc + 8'd1;
    if (op == OP_JMP) pc_next = pc + 8'd1 + {{2{instr[5]}}, instr[5:0]};
  end

  // NOTE: state updates use non-blocking assignments so every write commits together at the edge.
  // NOTE: the data memory is built from resettable flops because it must reload MEM[a]=a on reset.
  always_ff @(posedge clk) begin
    if (Reset) begin
      pc        <= 8'd0;
      RawOutput <= 8'd0;
      for (int i = 0; i < 4; i++) regs[i] <= 8'd0;
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
    end else begin
      pc <= pc_next;
      case (op)
        OP_ADD: begin
          regs[rd]  <= sum;
          RawOutput <= sum;
        end
        OP_LW: begin
          regs[rt]  <= load;
          RawOutput <= load;
        end
        OP_SW:   mem[addr] <= regs[rt];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_test.sv
// Self-checking bench for test: per-edge expected RawOutput/PC pushed to queues
// when each edge is driven, popped and compared after the edge.
module tb_test;

  logic       clk;
  logic       Reset;
  logic [7:0] RawOutput;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  logic [7:0] raw_q [$];
  logic [7:0] pc_q  [$];

  test dut (
    .clk      (clk),
    .Reset    (Reset),
    .RawOutput(RawOutput)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Expected RawOutput after the n-th non-reset edge since reset release.
  function automatic logic [7:0] exp_raw(input int k);
    logic [7:0] head [8];
    int e;
    head = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd6, 8'd6};
    if (k <= 7) return head[k];
    e = (k % 2 == 0) ? k : k - 1;
    return 8'((6 + 3 * ((e - 6) / 2)) % 256);
  endfunction

  function automatic logic [7:0] exp_pc(input int k);
    if (k <= 6) return 8'(k);
    return (k % 2 == 1) ? 8'd5 : 8'd6;
  endfunction

  task automatic step(input logic rst);
    Reset = rst;
    if (rst) n = 0;
    else     n++;
    raw_q.push_back(exp_raw(n));
    pc_q.push_back(exp_pc(n));
    @(posedge clk);
    #1;
    check($sformatf("raw n=%0d rst=%0b", n, rst), RawOutput, raw_q.pop_front());
    check($sformatf("pc n=%0d rst=%0b", n, rst), dut.pc, pc_q.pop_front());
  endtask

  initial begin
    Reset = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1);
    check("mem5 after reset", dut.mem[5], 8'd5);
    check("mem0 after reset", dut.mem[0], 8'd0);

    for (int i = 1; i <= 49; i++) begin
      step(1'b0);
      if (n == 4) check("mem0 after sw", dut.mem[0], 8'd3);
      if (n == 5) check("r0 after lw", dut.regs[0], 8'd3);
    end

    // One reset edge mid-program must restore the initial state.
    step(1'b1);
    check("mem0 restored", dut.mem[0], 8'd0);
    check("mem5 restored", dut.mem[5], 8'd5);
    check("r3 cleared", dut.regs[3], 8'd0);

    for (int i = 1; i <= 176; i++) step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=0 want=1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/test.md
Name: test

Overview:
- Top-level of an 8-bit single-cycle microprocessor with a built-in instruction ROM, a 4-entry register file and a 32-byte data memory.
- Executes a fixed program from reset, one instruction per clock.
- Drives RawOutput with the most recent register write-back value, for observation on the display path and in simulation.

Parameters:
- None. All widths and ROM contents are fixed.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- Reset  input  1  synchronous, active-high reset
- RawOutput  output  8  last value written to the register file

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset applies at the rising edge while Reset=1:
  - PC=0.
  - R0..R3=0.
  - MEM[a]=a for a=0..31.
  - RawOutput=0.
  - No instruction executes on a reset edge.
- Reset mid-program restarts identically from PC=0.
- State:
  - PC: 8 bits.
  - Registers R0..R3: 8 bits each.
  - MEM: 32x8.
  - ROM: 32x8, indexed by PC[4:0].
- Instruction fields: op=[7:6], rs=[5:4], rt=[3:2], rd=[1:0].
  - imm2=[1:0], signed.
  - imm6=[5:0], signed.
- op 00, ADD: R[rd] = (R[rs]+R[rt]) mod 256. RawOutput = sum. PC += 1.
- op 01, LW: R[rt] = MEM[(R[rs]+sext(imm2))[4:0]]. RawOutput = loaded value. PC += 1.
- op 10, SW: MEM[(R[rs]+sext(imm2))[4:0]] = R[rt]. RawOutput holds. PC += 1.
- op 11, JMP: PC = PC+1+sext(imm6), mod 256. RawOutput holds. No register or memory write.
- Combinational reads: register and ROM reads are combinational.
  - Memory read is combinational within the cycle.
  - All writes (register, memory, PC, RawOutput) commit at the same rising edge.
- Address arithmetic is 8-bit; data address uses the low 5 bits (wraps 31→0).
- ROM contents:
  - 0:0x45 (LW R1,[R0+1])
  - 1:0x16 (ADD R2=R1+R1)
  - 2:0x27 (ADD R3=R2+R1)
  - 3:0x8C (SW R3,[R0+0])
  - 4:0x40 (LW R0,[R0+0])
  - 5:0x30 (ADD R0=R3+R0)
  - 6:0xFE (JMP -2 → PC=5)
  - 7..31: 0x00 (unreached)
- Resulting RawOutput after the Nth rising edge with Reset=0:
  - N=1..7: 1, 2, 3, 3, 3, 6, 6.
  - Thereafter R0 increases by 3 on each even edge: edge 6+2k gives (6+3k) mod 256; the following odd edge (JMP) holds.
- RawOutput is a registered output; no combinational path from Reset or clk.

Test Plan:
- Reset held 5 edges → RawOutput=0, PC=0; MEM[5]=5.
- Release reset: edges 1..7 → RawOutput 1, 2, 3, 3, 3, 6, 6.
- After SW at edge 4 → MEM[0]=3; after edge 5 → R0=3.
- Loop:
  - Edge 8 → 9.
  - Edge 10 → 12.
  - Edge 20 → 27.
  - Each JMP edge holds the previous value; PC alternates 5/6.
- Wrap-around:
  - Edge 172 → 255.
  - Edge 174 → 2, since 258 mod 256.
- Assert Reset=1 for one edge at edge 50 → RawOutput=0, MEM restored.
  - After release, the sequence 1, 2, 3, 3, 3, 6 repeats.
